// File: rtl/mem_sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package mem_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_DONE
  } state_e;

  localparam logic [31:0] SRAM_BASE_ADDR_DEF = 32'd1024;
  localparam int unsigned SRAM_DW            = 16;
  localparam int unsigned SRAM_AW_DEF        = 18;

endpackage

// File: rtl/mem_sram_ctrl_tristate.sv
// Bidirectional driver for the SRAM data bus.
module sram_tristate #(
  parameter int unsigned W = 16
) (
  input  logic         oe_i,
  input  logic [W-1:0] out_i,
  output logic [W-1:0] in_o,
  inout  wire  [W-1:0] dq_io
);

  assign dq_io = oe_i ? out_i : 'z;
  assign in_o  = dq_io;

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage bridge to a 16-bit async SRAM: each 32-bit access runs as two half-word phases.
// Optional macro SRAM_BOUNDS_CHECK_EN: out-of-range accesses skip the SRAM and set sticky err.
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR_DEF,
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned SRAM_AW     = SRAM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               err
);

  localparam int unsigned   CW       = $clog2(WAIT_CYCLES + 2);
  localparam logic [CW-1:0] RD_START = CW'(WAIT_CYCLES - 1);
  // Writes need at least one low cycle plus one hold cycle per phase.
  localparam logic [CW-1:0] WR_START = (WAIT_CYCLES == 1) ? CW'(1) : CW'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         off;
  logic [SRAM_AW-2:0]  widx;
  logic                oob;
  logic                hi;
  logic                dq_oe;
  logic [SRAM_DW-1:0]  dq_out, dq_in;
  logic                unused_bits;

  assign off  = address - BASE_ADDR;
  assign widx = off[SRAM_AW:2];
  assign hi   = (state_q == ST_HI);

`ifdef SRAM_BOUNDS_CHECK_EN
  logic err_q, err_d;
  assign oob         = (address < BASE_ADDR) | (|off[31:SRAM_AW+1]);
  assign err         = err_q;
  assign unused_bits = ^off[1:0];
`else
  logic err_d;
  assign oob         = 1'b0;
  assign err         = 1'b0;
  assign unused_bits = ^{off[1:0], off[31:SRAM_AW+1], err_d};
`endif

  sram_tristate #(.W(SRAM_DW)) u_dq (
    .oe_i  (dq_oe),
    .out_i (dq_out),
    .in_o  (dq_in),
    .dq_io (SRAM_DQ)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
`ifdef SRAM_BOUNDS_CHECK_EN
    err_d     = err_q;
`else
    err_d     = 1'b0;
`endif
    ready     = 1'b0;
    SRAM_CE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_ADDR = '0;
    dq_oe     = 1'b0;
    dq_out    = '0;
    unique case (state_q)
      ST_IDLE: begin
        ready = ~(MEM_R_EN | MEM_W_EN);
        if (MEM_R_EN | MEM_W_EN) begin
          if (oob) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            if (!MEM_W_EN) rdata_d = '0;
          end else begin
            state_d = ST_LO;
            cnt_d   = MEM_W_EN ? WR_START : RD_START;
          end
        end
      end
      ST_LO, ST_HI: begin
        SRAM_CE_N = 1'b0;
        SRAM_ADDR = {widx, hi};
        if (MEM_W_EN) begin
          // Last cycle of the phase releases WE_N with address/data still held.
          SRAM_WE_N = (cnt_q == '0);
          dq_oe     = 1'b1;
          dq_out    = hi ? wdata[31:16] : wdata[15:0];
        end else begin
          SRAM_OE_N = 1'b0;
        end
        if (cnt_q == '0) begin
          if (!MEM_W_EN) begin
            if (hi) rdata_d[31:16] = dq_in;
            else    rdata_d[15:0]  = dq_in;
          end
          if (hi) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_HI;
            cnt_d   = MEM_W_EN ? WR_START : RD_START;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        ready   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
`ifdef SRAM_BOUNDS_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
`ifdef SRAM_BOUNDS_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign rdata = rdata_q;

endmodule
